// File: rtl/lcd_scan_pkg.sv
// Shared constants and FSM encoding for the LCD raster scanner and its
// neighbours in the pixel path.
package lcd_scan_pkg;
  localparam int DEF_WIDTH       = 240;
  localparam int DEF_HEIGHT      = 320;
  localparam int DEF_BITS_WIDTH  = 8;
  localparam int DEF_BITS_HEIGHT = 9;

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} scan_state_e;
endpackage

// File: rtl/lcd_raster_scanner_if.sv
// Pixel address stream from the scanner to the LCD writer and overlay logic.
interface lcd_raster_scanner_if #(
  parameter int BITS_WIDTH  = lcd_scan_pkg::DEF_BITS_WIDTH,
  parameter int BITS_HEIGHT = lcd_scan_pkg::DEF_BITS_HEIGHT
);
  logic [BITS_WIDTH-1:0]  xAddr;
  logic [BITS_HEIGHT-1:0] yAddr;
  logic                   pixelValid;
  logic                   pixelReady;
  logic                   lineDone;
  logic                   frameDone;

  modport master (output xAddr, yAddr, pixelValid, lineDone, frameDone, input pixelReady);
  modport slave  (input xAddr, yAddr, pixelValid, lineDone, frameDone, output pixelReady);
endinterface

// File: rtl/scan_axis_counter.sv
// One coordinate counter; the top decides whether it is the inner or outer axis
// by steering load/inc. It saturates at endValue so it never wraps on its own.
module scan_axis_counter #(
  parameter int BITS = 8
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            load,
  input  logic [BITS-1:0] loadValue,
  input  logic [BITS-1:0] endValue,
  input  logic            inc,
  output logic [BITS-1:0] value,
  output logic            atEnd
);
  logic [BITS-1:0] value_d, value_q;

  assign atEnd = (value_q == endValue);
  assign value = value_q;

  always_comb begin
    value_d = value_q;
    if (load)             value_d = loadValue;
    else if (inc && !atEnd) value_d = value_q + 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) value_q <= '0;
    else         value_q <= value_d;
  end
endmodule

// File: rtl/lcd_raster_scanner.sv
// Raster address generator: walks a programmable window row- or column-major
// under valid/ready backpressure, with line/frame strobes.
module lcd_raster_scanner
  import lcd_scan_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int HEIGHT      = DEF_HEIGHT,
  parameter int BITS_WIDTH  = DEF_BITS_WIDTH,
  parameter int BITS_HEIGHT = DEF_BITS_HEIGHT
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   continuous,
  input  logic                   columnMajor,
  input  logic [BITS_WIDTH-1:0]  xStart,
  input  logic [BITS_WIDTH-1:0]  xEnd,
  input  logic [BITS_HEIGHT-1:0] yStart,
  input  logic [BITS_HEIGHT-1:0] yEnd,
  output logic                   busy,
  output logic                   startError,
  lcd_raster_scanner_if.master   pix
);
  localparam logic [BITS_WIDTH-1:0]  X_MAX = BITS_WIDTH'(WIDTH - 1);
  localparam logic [BITS_HEIGHT-1:0] Y_MAX = BITS_HEIGHT'(HEIGHT - 1);

  scan_state_e            state_d, state_q;
  logic [BITS_WIDTH-1:0]  x_start_d, x_start_q, x_end_d, x_end_q, x_end_c, x_val, x_load_val;
  logic [BITS_HEIGHT-1:0] y_start_d, y_start_q, y_end_d, y_end_q, y_end_c, y_val, y_load_val;
  logic cont_d, cont_q, col_d, col_q;
  logic pixel_valid_d, pixel_valid_q, line_done_d, line_done_q;
  logic frame_done_d, frame_done_q, start_error_d, start_error_q;
  logic win_bad, start_ok, start_bad, xfer, x_at_end, y_at_end, in_end, out_end;
  logic line_end, frame_end, inner_load, inner_inc, outer_load, outer_inc;
  logic x_load, x_inc, y_load, y_inc;

  assign x_end_c   = (xEnd > X_MAX) ? X_MAX : xEnd;
  assign y_end_c   = (yEnd > Y_MAX) ? Y_MAX : yEnd;
  assign win_bad   = (xStart > x_end_c) || (yStart > y_end_c);
  assign start_ok  = (state_q == IDLE) && start && !win_bad;
  assign start_bad = (state_q == IDLE) && start && win_bad;

  // Stop wins over a coincident handshake: that pixel is not consumed.
  assign xfer      = (state_q == SCAN) && pixel_valid_q && pix.pixelReady && !stop;
  assign in_end    = col_q ? y_at_end : x_at_end;
  assign out_end   = col_q ? x_at_end : y_at_end;
  assign line_end  = xfer && in_end;
  assign frame_end = line_end && out_end;

  // A single-shot frame end loads nothing so the last address stays visible.
  assign inner_load = line_end && (!out_end || cont_q);
  assign inner_inc  = xfer && !in_end;
  assign outer_load = frame_end && cont_q;
  assign outer_inc  = line_end && !out_end;

  assign x_load     = start_ok || (col_q ? outer_load : inner_load);
  assign x_inc      = col_q ? outer_inc : inner_inc;
  assign y_load     = start_ok || (col_q ? inner_load : outer_load);
  assign y_inc      = col_q ? inner_inc : outer_inc;
  assign x_load_val = start_ok ? xStart : x_start_q;
  assign y_load_val = start_ok ? yStart : y_start_q;

  scan_axis_counter #(.BITS(BITS_WIDTH)) u_x_cnt (
    .clock(clock), .resetn(resetn), .load(x_load), .loadValue(x_load_val),
    .endValue(x_end_q), .inc(x_inc), .value(x_val), .atEnd(x_at_end)
  );

  scan_axis_counter #(.BITS(BITS_HEIGHT)) u_y_cnt (
    .clock(clock), .resetn(resetn), .load(y_load), .loadValue(y_load_val),
    .endValue(y_end_q), .inc(y_inc), .value(y_val), .atEnd(y_at_end)
  );

  always_comb begin
    state_d       = state_q;
    pixel_valid_d = pixel_valid_q;
    x_start_d     = x_start_q;
    x_end_d       = x_end_q;
    y_start_d     = y_start_q;
    y_end_d       = y_end_q;
    cont_d        = cont_q;
    col_d         = col_q;
    line_done_d   = line_end;
    frame_done_d  = frame_end;
    start_error_d = start_bad;
    case (state_q)
      IDLE: if (start_ok) begin
        state_d       = SCAN;
        pixel_valid_d = 1'b1;
        x_start_d     = xStart;
        x_end_d       = x_end_c;
        y_start_d     = yStart;
        y_end_d       = y_end_c;
        cont_d        = continuous;
        col_d         = columnMajor;
      end
      SCAN: if (stop || (frame_end && !cont_q)) begin
        state_d       = IDLE;
        pixel_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      pixel_valid_q <= 1'b0;
      x_start_q     <= '0;
      x_end_q       <= '0;
      y_start_q     <= '0;
      y_end_q       <= '0;
      cont_q        <= 1'b0;
      col_q         <= 1'b0;
      line_done_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      start_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pixel_valid_q <= pixel_valid_d;
      x_start_q     <= x_start_d;
      x_end_q       <= x_end_d;
      y_start_q     <= y_start_d;
      y_end_q       <= y_end_d;
      cont_q        <= cont_d;
      col_q         <= col_d;
      line_done_q   <= line_done_d;
      frame_done_q  <= frame_done_d;
      start_error_q <= start_error_d;
    end
  end

  assign busy           = (state_q == SCAN);
  assign startError     = start_error_q;
  assign pix.xAddr      = x_val;
  assign pix.yAddr      = y_val;
  assign pix.pixelValid = pixel_valid_q;
  assign pix.lineDone   = line_done_q;
  assign pix.frameDone  = frame_done_q;
endmodule

// File: tb/tb_lcd_raster_scanner.sv
// Randomized bench for lcd_raster_scanner: expected pixel order is built as a
// list from the window rules and consumed on every accepted handshake.
module tb_lcd_raster_scanner;
  localparam int W  = 240;
  localparam int H  = 320;
  localparam int BW = 8;
  localparam int BH = 9;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0, stop = 1'b0, continuous = 1'b0, columnMajor = 1'b0;
  logic [BW-1:0] xStart = '0, xEnd = '0;
  logic [BH-1:0] yStart = '0, yEnd = '0;
  logic busy, startError;
  int checks = 0;
  int errors = 0;

  lcd_raster_scanner_if #(.BITS_WIDTH(BW), .BITS_HEIGHT(BH)) pix ();

  lcd_raster_scanner #(.WIDTH(W), .HEIGHT(H), .BITS_WIDTH(BW), .BITS_HEIGHT(BH)) dut (
    .clock(clock), .resetn(resetn), .start(start), .stop(stop),
    .continuous(continuous), .columnMajor(columnMajor),
    .xStart(xStart), .xEnd(xEnd), .yStart(yStart), .yEnd(yEnd),
    .busy(busy), .startError(startError), .pix(pix)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, int'(pix.pixelValid), 0);
    check({tag, "_busy"},  int'(busy), 0);
    check({tag, "_line"},  int'(pix.lineDone), 0);
    check({tag, "_frame"}, int'(pix.frameDone), 0);
    check({tag, "_serr"},  int'(startError), 0);
  endtask

  // Runs one scan: stop_after = transfer index at which stop rides along with a
  // handshake (-1 none); hold_at = transfer index before which ready drops 4 cycles.
  task automatic scan(input int xs, xe, ys, ye, input bit col, cont,
                      input int stop_after, hold_at, rdy_pct);
    int cxe, cye, n, inner_len, idx, hold_cnt, k;
    int px[$], py[$];
    bit rdy, stp, el, ef, done;
    cxe = (xe > W-1) ? W-1 : xe;
    cye = (ye > H-1) ? H-1 : ye;
    if (!col) begin
      for (int y = ys; y <= cye; y++) for (int x = xs; x <= cxe; x++) begin px.push_back(x); py.push_back(y); end
    end else begin
      for (int x = xs; x <= cxe; x++) for (int y = ys; y <= cye; y++) begin px.push_back(x); py.push_back(y); end
    end
    n = px.size();
    inner_len = col ? (cye - ys + 1) : (cxe - xs + 1);

    @(negedge clock);
    xStart = BW'(xs); xEnd = BW'(xe); yStart = BH'(ys); yEnd = BH'(ye);
    columnMajor = col; continuous = cont; start = 1'b1; pix.pixelReady = 1'b0;
    @(negedge clock);
    start = 1'b0;
    if (n == 0) begin
      check("bad_start_err", int'(startError), 1);
      check("bad_busy", int'(busy), 0);
      check("bad_valid", int'(pix.pixelValid), 0);
      @(negedge clock);
      check("bad_err_pulse", int'(startError), 0);
      return;
    end
    check("good_serr", int'(startError), 0);

    el = 0; ef = 0; idx = 0; hold_cnt = 0; done = 0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      check("valid", int'(pix.pixelValid), 1);
      check("busy", int'(busy), 1);
      check("x", int'(pix.xAddr), px[idx % n]);
      check("y", int'(pix.yAddr), py[idx % n]);
      check("line", int'(pix.lineDone), int'(el));
      check("frame", int'(pix.frameDone), int'(ef));
      check("serr_scan", int'(startError), 0);
      rdy = ($urandom_range(99) < rdy_pct);
      if (idx == hold_at && hold_cnt < 4) begin rdy = 0; hold_cnt++; end
      stp = (idx == stop_after) && rdy;
      pix.pixelReady = rdy;
      stop = stp;
      start = stp | ($urandom_range(7) == 0);
      xStart = BW'($urandom); yStart = BH'($urandom);
      @(negedge clock);
      stop = 1'b0; start = 1'b0;
      if (stp) begin
        check_idle_outputs("stop");
        done = 1;
      end else if (rdy) begin
        k  = idx % n;
        el = ((k + 1) % inner_len) == 0;
        ef = (k == n - 1);
        idx++;
        if (ef && !cont) begin
          check("end_line", int'(pix.lineDone), 1);
          check("end_frame", int'(pix.frameDone), 1);
          check("end_valid", int'(pix.pixelValid), 0);
          check("end_busy", int'(busy), 0);
          check("end_x_hold", int'(pix.xAddr), px[n-1]);
          check("end_y_hold", int'(pix.yAddr), py[n-1]);
          done = 1;
        end
      end else begin
        el = 0; ef = 0;
      end
    end
    if (!done) check("scan_timeout", 0, 1);
    pix.pixelReady = 1'b0;
    @(negedge clock);
    check("post_line", int'(pix.lineDone), 0);
    check("post_frame", int'(pix.frameDone), 0);
    check("post_busy", int'(busy), 0);
  endtask

  initial begin
    int xs, ys;
    pix.pixelReady = 1'b0;
    #12;
    check_idle_outputs("rst");
    check("rst_x", int'(pix.xAddr), 0);
    check("rst_y", int'(pix.yAddr), 0);
    @(negedge clock);
    resetn = 1'b1;

    // Reset in the middle of a 10x10 scan while sitting on (5,3).
    @(negedge clock);
    xStart = 0; xEnd = 9; yStart = 0; yEnd = 9; columnMajor = 0; continuous = 0;
    start = 1'b1; pix.pixelReady = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 35; i++) @(negedge clock);
    check("pre_rst_x", int'(pix.xAddr), 5);
    check("pre_rst_y", int'(pix.yAddr), 3);
    #2 resetn = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    check("async_rst_x", int'(pix.xAddr), 0);
    check("async_rst_y", int'(pix.yAddr), 0);
    @(negedge clock);
    check("rst_hold_frame", int'(pix.frameDone), 0);
    pix.pixelReady = 1'b0;
    resetn = 1'b1;

    // Stop while idle does nothing.
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    check_idle_outputs("idle_stop");

    scan(10, 12, 20, 21, 0, 0, -1, 1, 100);   // row-major, stall at (11,20)
    scan(10, 12, 20, 21, 1, 0, -1, -1, 100);  // column-major
    scan(0, 1, 0, 1, 0, 1, 7, -1, 100);       // continuous 2x2, stop at (1,1) of frame 2
    scan(50, 40, 0, 3, 0, 0, -1, -1, 100);    // rejected window
    scan(236, 255, 5, 6, 0, 0, -1, -1, 100);  // x end clamped to 239
    scan(7, 7, 9, 9, 0, 1, 5, -1, 60);        // 1x1 continuous
    scan(0, 2, 316, 400, 1, 0, -1, -1, 70);   // y end clamped to 319
    for (int r = 0; r < 6; r++) begin
      xs = $urandom_range(230);
      ys = $urandom_range(310);
      scan(xs, xs + $urandom_range(4), ys, ys + $urandom_range(4),
           1'($urandom_range(1)), 1'b0, -1, -1, 70);
    end
    scan(3, 5, 9, 8, 1, 0, -1, -1, 100);      // rejected on y

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
